// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
// Ovf is present only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
`ifdef SERSUB_OVF_EN
  logic             Ovf;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout, Ovf
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout, Ovf
  );
`else
  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock; result after WIDTH cycles.
// Optional signed overflow flag Ovf enabled by macro SERSUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             h1_d;
  logic             h1_b;
  logic             h2_b;
  logic             d_bit;
  logic             br_nx;

  // Two cascaded half subtractors: a-b, then minus borrow-in.
  always_comb begin
    h1_d  = a_sh[0] ^ b_sh[0];
    h1_b  = ~a_sh[0] & b_sh[0];
    d_bit = h1_d ^ br;
    h2_b  = ~h1_d & br;
    br_nx = h1_b | h2_b;
  end

  assign last = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef SERSUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand MSBs are shifted out, so keep the sign bits separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      a_msb <= bus.A[WIDTH-1];
      b_msb <= bus.B[WIDTH-1];
    end else if (step && last) begin
      ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end

  assign bus.Ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      diff_q <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= bus.A;
      b_sh   <= bus.B;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {d_bit, res_sh[WIDTH-1:1]};
      br     <= br_nx;
      cnt    <= cnt + 1'b1;
      if (last) begin
        diff_q <= {d_bit, res_sh[WIDTH-1:1]};
        bout_q <= br_nx;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor, WIDTH=8.
// Ovf checks are compiled in only with SERSUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_ovf(input string nm, input logic exp);
`ifdef SERSUB_OVF_EN
    check({nm, ".ovf"}, {31'd0, bus.Ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unexpected x in %s", nm);
`endif
  endtask

  // One operation; noise=1 pulses start and scrambles A/B mid-shift.
  task automatic run_op(input vec_t v, input bit noise);
    int         busy_n;
    int         lat;
    logic       diff_bad;
    logic [7:0] prev;
    busy_n   = 0;
    lat      = -1;
    diff_bad = 1'b0;
    @(negedge clk);
    prev      = bus.Diff;
    bus.start = 1'b1;
    bus.A     = v.a;
    bus.B     = v.b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int s = 0; s <= W + 4; s++) begin
      if (bus.done) begin
        lat = s;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.Diff !== prev) diff_bad = 1'b1;
      if (noise) begin
        bus.start = (s == 2 || s == 3);
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    check({v.name, ".lat"}, lat, W);
    check({v.name, ".busy_cycles"}, busy_n, W);
    check({v.name, ".diff_held"}, {31'd0, diff_bad}, 32'd0);
    check({v.name, ".diff"}, {24'd0, bus.Diff}, {24'd0, v.diff});
    check({v.name, ".bout"}, {31'd0, bus.Bout}, {31'd0, v.bout});
    check_ovf(v.name, v.ovf);
    @(posedge clk);
    #1;
    check({v.name, ".done_drop"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   dn[3];
    int   nd;
    int   bad_res;
    logic seen;

    tests  = 0;
    failed = 0;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "5a_3c"};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "03_05"};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80_01"};
    vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "00_01"};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7f_ff"};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "00_00"};
    vecs[6] = '{8'hC3, 8'h81, 8'h42, 1'b0, 1'b0, "c3_81"};
    vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1, "01_80"};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {bus.Diff, 6'd0, bus.busy, bus.done}, 32'd0);
    check("reset.bout", {31'd0, bus.Bout}, 32'd0);
    check_ovf("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], 1'b0);

    v = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "ff_ff_noise"};
    run_op(v, 1'b1);

    // Abort mid-shift: reset lands after four bits have been processed.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'hF0;
    bus.B     = 8'h0F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort.busy", {31'd0, bus.busy}, 32'd0);
    check("abort.diff", {24'd0, bus.Diff}, 32'd0);
    check("abort.bout", {31'd0, bus.Bout}, 32'd0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    rst = 1'b0;
    check("abort.no_done", {31'd0, seen}, 32'd0);
    v = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "after_abort"};
    run_op(v, 1'b0);

    // Back-to-back: start held high, operands swapped after each done.
    nd      = 0;
    bad_res = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = vecs[0].a;
    bus.B     = vecs[0].b;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dn[nd] = c;
        if (bus.Diff !== vecs[nd].diff || bus.Bout !== vecs[nd].bout)
          bad_res++;
        nd++;
        if (nd < 3) begin
          bus.A = vecs[nd].a;
          bus.B = vecs[nd].b;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b.count", nd, 3);
    check("b2b.results", bad_res, 0);
    if (nd == 3) begin
      check("b2b.first", dn[0], W);
      check("b2b.gap1", dn[1] - dn[0], W + 2);
      check("b2b.gap2", dn[2] - dn[1], W + 2);
    end
    check_ovf("b2b.last", vecs[2].ovf);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend, captured on accepted start.
REQ-006 The block SHALL have port B, input, WIDTH bits: subtrahend, captured on accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port Diff, output, WIDTH bits: result A-B modulo 2^WIDTH.
REQ-010 The block SHALL have port Bout, output, 1 bit: final borrow, high iff A < B unsigned.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL load A and B into internal shift registers, clear the borrow register and bit counter, and enter SHIFT.
REQ-013 Each SHIFT edge SHALL process one bit, LSB first, as two cascaded half-subtractor stages: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-014 Each SHIFT edge SHALL shift d into the MSB of an internal result register and advance the operand registers and counter.
REQ-015 After exactly WIDTH SHIFT edges (edges k+1..k+WIDTH), the block SHALL enter DONE at edge k+WIDTH and load Diff and Bout from the result and borrow registers at that edge.
REQ-016 done SHALL be high for exactly the one cycle in DONE; the FSM SHALL then return unconditionally to IDLE.
REQ-017 Diff and Bout SHALL hold their values until the next completion or reset; they SHALL NOT change during SHIFT.
REQ-018 start SHALL be ignored in SHIFT and DONE; A and B SHALL be ignored except at an accepted start.
REQ-019 Back-to-back operation: start high in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-020 busy and done SHALL be registered (state-decoded) outputs; there SHALL be no combinational path from any input to any output.

Reset
REQ-021 While rst=1, state SHALL be IDLE and busy, done, Diff, Bout, counter, borrow and all shift registers SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; Diff and Bout SHALL read 0 afterwards.
REQ-023 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-024 With macro SERSUB_OVF_EN defined, the block SHALL add output port Ovf (1 bit, reset 0), the signed two's-complement overflow flag: (A[MSB]!=B[MSB]) && (Diff[MSB]!=A[MSB]), updated together with Diff.
REQ-025 Without SERSUB_OVF_EN, Ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover: A=8'h5A, B=8'h3C, start at edge k -> busy for 8 cycles; done at edge k+8; Diff=8'h1E; Bout=0.
REQ-027 The bench SHALL cover: A=8'h03, B=8'h05 -> Diff=8'hFE, Bout=1; with SERSUB_OVF_EN, Ovf=0.
REQ-028 The bench SHALL cover: A=8'h80, B=8'h01 with SERSUB_OVF_EN -> Diff=8'h7F, Bout=0, Ovf=1.
REQ-029 The bench SHALL cover: A=B=8'hFF; a second start pulse and A/B changes during SHIFT -> single done, Diff=8'h00, Bout=0, second start ignored.
REQ-030 The bench SHALL cover: rst pulsed at SHIFT bit 4 of A=8'hF0, B=8'h0F -> busy drops immediately, no done, Diff=0; a following start with A=8'h10, B=8'h01 -> Diff=8'h0F.
REQ-031 The bench SHALL cover: back-to-back starts, issued in the IDLE cycle right after each DONE -> done pulses spaced exactly 10 cycles apart, each result correct.
